piso_shift_reg: RTL and testbench
=================================

Name: piso_shift_reg

Overview:
Parallel-in serial-out shift register.
- Captures a parallel word on a load cycle, then shifts it out MSB-first, one bit per clock.
- Sits between a parallel data source and a single-wire serial sink, such as a serial transmitter front end.
- The full register contents stay visible on a parallel output for debug and monitoring.

Parameters:
- WIDTH, 4, number of bits in the parallel word and in the shift register (must be ≥ 2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-high; clears all state.
- load  input  1  1 = capture `in` on the next rising edge; 0 = shift on each rising edge.
- in  input  WIDTH  parallel data word.
- out  output  WIDTH  current shift-register contents, registered.
- out_series  output  1  serial data bit, equal to out[WIDTH-1].

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-high.
- While reset=1:
  - out = 0 immediately, independent of clk.
  - out_series = 0.
  - All edges are ignored.
- Reset deassertion takes effect from the next rising edge. Reset in mid-shift aborts the word; out and out_series go to 0.
- On a rising edge with reset=0 and load=1:
  - out <= in.
  - Zero-cycle capture: out_series shows in[WIDTH-1] right after that edge.
- On a rising edge with reset=0 and load=0:
  - out <= {out[WIDTH-2:0], 1'b0}, i.e. shift left with zero fill.
  - The bit shifted out of the MSB is discarded.
- out_series is a continuous assignment from out[WIDTH-1]. No extra register stage.
- Serial sequence after a load edge:
  - The bits of the loaded word appear MSB first: bit WIDTH-1, then WIDTH-2, down to 0.
  - Each bit is valid for one clock period; the first is valid immediately after the load edge.
- After WIDTH-1 shift edges the LSB is on out_series. The next shift leaves out = 0, and further shifts hold 0.
- load has priority: asserting load at any time, including mid-shift, overwrites the register and restarts the sequence.
- Holding load=1 for several cycles reloads `in` every edge. No shifting occurs.
- No handshake, no stall: the register shifts on every non-load edge.
- Outputs have no X after reset. An `in` containing X/Z is not a legal stimulus.

Optional Feature:
Macro: PISO_DONE_EN.
- Defined:
  - Adds output port `done` (1 bit) and an internal shift counter, ceil(log2(WIDTH+1)) bits.
  - Counter clears on reset and on each load edge. It increments on each shift edge and saturates at WIDTH.
  - done = 1 when the counter equals WIDTH-1 (LSB on out_series), else 0.
  - done reset value: 0.
- Undefined:
  - No `done` port and no counter.
  - Datapath behaviour is identical in both builds.

Test Plan:
1. Reset: reset=1, load=0, in=0000 for 10 ns -> out=0000 and out_series=0 immediately. No change across clk edges while reset is held.
2. Load and shift, WIDTH=4:
   - Deassert reset, idle one cycle. Then load=1, in=1101 for one edge -> out=1101, out_series=1.
   - load=0 for 4 edges -> out = 1010, 0100, 1000, 0000.
   - out_series sequence from the load edge: 1,1,0,1,0.
3. Drain hold: after the case-2 drain, 2 more shift edges -> out stays 0000, out_series=0.
4. Reload mid-shift:
   - Load 1101, shift 2 edges (out=0100).
   - Then load=1 with in=0110 -> out=0110 on that edge; serial sequence restarts 0,1,1,0.
5. Asynchronous reset mid-shift:
   - Load 1111, shift 1 edge (out=1110).
   - Assert reset between edges -> out=0000 before the next edge; stays 0 after release until a load.
6. PISO_DONE_EN build: load 1001, then 3 shift edges -> done=0,0,0 after load/shift 1/shift 2, done=1 after shift 3. The next shift -> done=0.

Source files
------------

// File: rtl/piso_shift_reg_if.sv
// Bus bundle for piso_shift_reg: parallel load side plus register/serial outputs.
// With PISO_DONE_EN defined, the bundle also carries the 'done' flag.
interface piso_shift_reg_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic             out_series;
`ifdef PISO_DONE_EN
    logic             done;

    modport master (output load, output in, input out, input out_series, input done);
    modport slave  (input load, input in, output out, output out_series, output done);
`else
    modport master (output load, output in, input out, input out_series);
    modport slave  (input load, input in, output out, output out_series);
`endif
endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register, MSB first, zero fill.
// Optional macro PISO_DONE_EN adds a shift counter and a 'done' flag that
// marks the cycle in which the LSB is on out_series.
module piso_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    piso_shift_reg_if.slave   bus
);
    logic [WIDTH-1:0] shreg;

    // Load has priority over shifting; reset clears the word at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            shreg <= '0;
        else if (bus.load)
            shreg <= bus.in;
        else
            shreg <= {shreg[WIDTH-2:0], 1'b0};
    end

    assign bus.out        = shreg;
    assign bus.out_series = shreg[WIDTH-1];

`ifdef PISO_DONE_EN
    localparam int CW = $clog2(WIDTH + 1);
    logic [CW-1:0] shift_cnt;

    // Counts shifts since the last load, saturating at WIDTH so it never wraps
    // back onto the done value during a long drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            shift_cnt <= '0;
        else if (bus.load)
            shift_cnt <= '0;
        else if (shift_cnt != CW'(WIDTH))
            shift_cnt <= shift_cnt + 1'b1;
    end

    assign bus.done = (shift_cnt == CW'(WIDTH - 1));
`endif
endmodule

// File: tb/tb_piso_shift_reg.sv
// Self-checking bench for piso_shift_reg: directed test-plan steps followed by
// randomized load/shift/reset traffic against a word-level reference model.
module tb_piso_shift_reg;
    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    piso_shift_reg_if #(.WIDTH(W)) bus ();

    piso_shift_reg #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the register as an integer, and shifts since last load.
    int mw     = 0;
    int nshift = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_out"}, 32'(bus.out), 32'(mw));
        chk({tag, "_ser"}, 32'(bus.out_series), 32'((mw >> (W - 1)) & 1));
`ifdef PISO_DONE_EN
        chk({tag, "_done"}, 32'(bus.done), 32'(nshift == W - 1));
`endif
    endtask

    // Called at a negedge: drive inputs, take one rising edge, check at the next negedge.
    task automatic step(input logic ld, input logic [W-1:0] din, input string tag);
        bus.load = ld;
        bus.in   = din;
        @(posedge clk);
        if (ld) begin
            mw     = int'(din);
            nshift = 0;
        end else begin
            mw = (mw * 2) & MASK;
            if (nshift < W) nshift++;
        end
        @(negedge clk);
        check_model(tag);
    endtask

    // Called at a negedge: pulse reset between edges and check the async clear.
    task automatic mid_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        mw     = 0;
        nshift = 0;
        check_model(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [W-1:0] exp_seq [4];
        logic [W-1:0] rnd;

        // 1. Reset, asynchronous and held across edges
        bus.load = 1'b0;
        bus.in   = '0;
        #2 check_model("rst_imm");
        bus.load = 1'b1;
        bus.in   = 4'b1111;
        repeat (2) begin
            @(negedge clk);
            check_model("rst_hold");
        end
        bus.load = 1'b0;
        reset = 1'b0;

        // 2. Idle, load 1101, shift four times
        step(1'b0, 4'b0000, "idle");
        step(1'b1, 4'b1101, "p2_load");
        chk("p2_load_const", 32'(bus.out), 32'hD);
        exp_seq = '{4'b1010, 4'b0100, 4'b1000, 4'b0000};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'b0000, "p2_shift");
            chk("p2_shift_const", 32'(bus.out), 32'(exp_seq[i]));
        end

        // 3. Drain hold
        repeat (2) begin
            step(1'b0, 4'b1111, "p3_hold");
            chk("p3_hold_const", 32'(bus.out), 32'h0);
        end

        // 4. Reload mid-shift
        step(1'b1, 4'b1101, "p4_load");
        step(1'b0, 4'b0000, "p4_sh1");
        step(1'b0, 4'b0000, "p4_sh2");
        chk("p4_mid_const", 32'(bus.out), 32'h4);
        step(1'b1, 4'b0110, "p4_reload");
        chk("p4_reload_const", 32'(bus.out), 32'h6);
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0000, "p4_seq");

        // 5. Async reset mid-shift
        step(1'b1, 4'b1111, "p5_load");
        step(1'b0, 4'b0000, "p5_sh1");
        chk("p5_sh1_const", 32'(bus.out), 32'hE);
        mid_reset("p5_rst");
        repeat (2) step(1'b0, 4'b0000, "p5_after");

        // 6. done flag timing (checked through the model when enabled)
        step(1'b1, 4'b1001, "p6_load");
        for (int i = 0; i < 5; i++) step(1'b0, 4'b0000, "p6_shift");

        // Held load reloads every edge
        for (int i = 0; i < 3; i++) begin
            rnd = W'($urandom);
            step(1'b1, rnd, "hold_load");
        end

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 24) == 0)
                mid_reset("rnd_rst");
            else begin
                rnd = W'($urandom);
                step(($urandom_range(0, 3) == 0), rnd, "rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
